// File: rtl/bck_fetch_stage3_if.sv
`timescale 1ns/1ps
// Port bundle for bck_fetch_stage3: stage-2 token in, RAM read ports, merged token out.
// The stage itself connects through the slave modport; its environment uses master.
interface bck_fetch_stage3_if #(
  parameter int INTV_W     = 64,
  parameter int RD_NUM_W   = 9,
  parameter int DONE_CNT_W = 10
);
  logic                    stall;
  logic                    stall_up;
  logic [5:0]              status_q;
  logic [RD_NUM_W-1:0]     read_num_q;
  logic [6:0]              backward_i_q;
  logic [6:0]              backward_j_q;
  logic [6:0]              current_rd_addr_q;
  logic [6:0]              min_intv_q;
  logic [63:0]             primary_q;
  logic                    finish_sign_q;
  logic                    iteration_boundary_q;
  logic                    query_rd_en;
  logic [RD_NUM_W+6:0]     query_rd_addr;
  logic [7:0]              query_rd_data;
  logic                    intv_rd_en;
  logic [6:0]              intv_rd_addr;
  logic [INTV_W-1:0]       intv_rd_data;
  logic [5:0]              status;
  logic [RD_NUM_W-1:0]     read_num;
  logic [6:0]              backward_i;
  logic [6:0]              backward_j;
  logic [6:0]              min_intv;
  logic [63:0]             primary;
  logic                    finish_sign;
  logic                    iteration_boundary;
  logic [7:0]              output_c;
  logic [INTV_W-1:0]       intv;
  logic                    ambig;
  logic [DONE_CNT_W-1:0]   reads_done;
  logic [31:0]             stall_cycles;

  modport slave (
    input  stall, status_q, read_num_q, backward_i_q, backward_j_q, current_rd_addr_q,
           min_intv_q, primary_q, finish_sign_q, iteration_boundary_q,
           query_rd_data, intv_rd_data,
    output stall_up, query_rd_en, query_rd_addr, intv_rd_en, intv_rd_addr,
           status, read_num, backward_i, backward_j, min_intv, primary, finish_sign,
           iteration_boundary, output_c, intv, ambig, reads_done, stall_cycles
  );

  modport master (
    output stall, status_q, read_num_q, backward_i_q, backward_j_q, current_rd_addr_q,
           min_intv_q, primary_q, finish_sign_q, iteration_boundary_q,
           query_rd_data, intv_rd_data,
    input  stall_up, query_rd_en, query_rd_addr, intv_rd_en, intv_rd_addr,
           status, read_num, backward_i, backward_j, min_intv, primary, finish_sign,
           iteration_boundary, output_c, intv, ambig, reads_done, stall_cycles
  );
endinterface

// File: rtl/bck_fetch_stage3.sv
`timescale 1ns/1ps
// Backward-extension fetch stage: 2-cycle pipeline that fetches the query base and interval
// for each stage-2 token. Define STAGE3_PERF_CNT_EN to build the stall_cycles counter.
module bck_fetch_stage3 #(
  parameter int INTV_W     = 64,
  parameter int RD_NUM_W   = 9,
  parameter int DONE_CNT_W = 10
) (
  input logic               clk,
  input logic               rst,
  bck_fetch_stage3_if.slave bus
);
  localparam logic [5:0] ST_BCK_INI = 6'h04;
  localparam logic [5:0] ST_BCK_RUN = 6'h05;
  localparam logic [5:0] ST_BUBBLE  = 6'h30;

  // {ambig, code}: ASCII letters and raw 2-bit codes both map onto 0..3
  function automatic logic [8:0] map_base(input logic [7:0] b);
    case (b)
      8'h41, 8'h61, 8'h00: map_base = {1'b0, 8'd0};
      8'h43, 8'h63, 8'h01: map_base = {1'b0, 8'd1};
      8'h47, 8'h67, 8'h02: map_base = {1'b0, 8'd2};
      8'h54, 8'h74, 8'h03: map_base = {1'b0, 8'd3};
      default:             map_base = {1'b1, 8'd4};
    endcase
  endfunction

  function automatic logic [DONE_CNT_W-1:0] sat_inc(input logic [DONE_CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(DONE_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic load;
  assign load = !bus.stall;

  // RAM requests are issued in the same cycle the token is presented; a stalled
  // RAM keeps its last read word, so no skid buffer is needed.
  assign bus.stall_up      = bus.stall;
  assign bus.query_rd_en   = load;
  assign bus.intv_rd_en    = load;
  assign bus.query_rd_addr = {bus.read_num_q, bus.backward_i_q};
  assign bus.intv_rd_addr  = bus.current_rd_addr_q;

  // ---- stage A: register incoming token ----
  logic                vld_p0;
  logic [5:0]          status_p0;
  logic [RD_NUM_W-1:0] read_num_p0;
  logic [6:0]          backward_i_p0;
  logic [6:0]          backward_j_p0;
  logic [6:0]          min_intv_p0;
  logic [63:0]         primary_p0;
  logic                finish_sign_p0;
  logic                iteration_boundary_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0                <= 1'b0;
      status_p0             <= ST_BUBBLE;
      read_num_p0           <= '0;
      backward_i_p0         <= '0;
      backward_j_p0         <= '0;
      min_intv_p0           <= '0;
      primary_p0            <= '0;
      finish_sign_p0        <= 1'b0;
      iteration_boundary_p0 <= 1'b0;
    end else if (load) begin
      vld_p0                <= (bus.status_q == ST_BCK_INI) || (bus.status_q == ST_BCK_RUN);
      status_p0             <= bus.status_q;
      read_num_p0           <= bus.read_num_q;
      backward_i_p0         <= bus.backward_i_q;
      backward_j_p0         <= bus.backward_j_q;
      min_intv_p0           <= bus.min_intv_q;
      primary_p0            <= bus.primary_q;
      finish_sign_p0        <= bus.finish_sign_q;
      iteration_boundary_p0 <= bus.iteration_boundary_q;
    end
  end

  // ---- stage B: merge token with RAM data and decode status ----
  logic [8:0]          base_d;
  logic [RD_NUM_W-1:0] read_num_d;
  logic [6:0]          backward_i_d;
  logic [6:0]          backward_j_d;
  logic [6:0]          min_intv_d;
  logic [63:0]         primary_d;
  logic                finish_sign_d;
  logic                iteration_boundary_d;
  logic [7:0]          output_c_d;
  logic [INTV_W-1:0]   intv_d;
  logic                ambig_d;

  always_comb begin
    base_d               = map_base(bus.query_rd_data);
    read_num_d           = '0;
    backward_i_d         = '0;
    backward_j_d         = '0;
    min_intv_d           = '0;
    primary_d            = '0;
    finish_sign_d        = 1'b0;
    iteration_boundary_d = 1'b0;
    output_c_d           = '0;
    intv_d               = '0;
    ambig_d              = 1'b0;
    if (vld_p0) begin
      read_num_d           = read_num_p0;
      backward_i_d         = backward_i_p0;
      backward_j_d         = backward_j_p0;
      min_intv_d           = min_intv_p0;
      primary_d            = primary_p0;
      finish_sign_d        = finish_sign_p0;
      iteration_boundary_d = iteration_boundary_p0;
      intv_d               = bus.intv_rd_data;
      if (status_p0 == ST_BCK_RUN) begin
        output_c_d = base_d[7:0];
        ambig_d    = base_d[8];
      end
    end
  end

  logic [5:0]            status_p1;
  logic [RD_NUM_W-1:0]   read_num_p1;
  logic [6:0]            backward_i_p1;
  logic [6:0]            backward_j_p1;
  logic [6:0]            min_intv_p1;
  logic [63:0]           primary_p1;
  logic                  finish_sign_p1;
  logic                  iteration_boundary_p1;
  logic [7:0]            output_c_p1;
  logic [INTV_W-1:0]     intv_p1;
  logic                  ambig_p1;
  logic [DONE_CNT_W-1:0] reads_done_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_p1             <= ST_BUBBLE;
      read_num_p1           <= '0;
      backward_i_p1         <= '0;
      backward_j_p1         <= '0;
      min_intv_p1           <= '0;
      primary_p1            <= '0;
      finish_sign_p1        <= 1'b0;
      iteration_boundary_p1 <= 1'b0;
      output_c_p1           <= '0;
      intv_p1               <= '0;
      ambig_p1              <= 1'b0;
      reads_done_p1         <= '0;
    end else if (load) begin
      status_p1             <= status_p0;
      read_num_p1           <= read_num_d;
      backward_i_p1         <= backward_i_d;
      backward_j_p1         <= backward_j_d;
      min_intv_p1           <= min_intv_d;
      primary_p1            <= primary_d;
      finish_sign_p1        <= finish_sign_d;
      iteration_boundary_p1 <= iteration_boundary_d;
      output_c_p1           <= output_c_d;
      intv_p1               <= intv_d;
      ambig_p1              <= ambig_d;
      if (vld_p0 && (status_p0 == ST_BCK_RUN) && finish_sign_p0)
        reads_done_p1 <= sat_inc(reads_done_p1);
    end
  end

  assign bus.status             = status_p1;
  assign bus.read_num           = read_num_p1;
  assign bus.backward_i         = backward_i_p1;
  assign bus.backward_j         = backward_j_p1;
  assign bus.min_intv           = min_intv_p1;
  assign bus.primary            = primary_p1;
  assign bus.finish_sign        = finish_sign_p1;
  assign bus.iteration_boundary = iteration_boundary_p1;
  assign bus.output_c           = output_c_p1;
  assign bus.intv               = intv_p1;
  assign bus.ambig              = ambig_p1;
  assign bus.reads_done         = reads_done_p1;

`ifdef STAGE3_PERF_CNT_EN
  // Counts cycles in which a real token is stuck in the output register.
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (bus.stall && (status_p1 != ST_BUBBLE))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bck_fetch_stage3.sv
`timescale 1ns/1ps
// Bench for bck_fetch_stage3: directed vector table, hand-written stall/reset/counter
// sequences and random traffic, all checked against a token-level delay-line model.
module tb_bck_fetch_stage3;
  localparam int INTV_W     = 64;
  localparam int RD_NUM_W   = 9;
  localparam int DONE_CNT_W = 10;
  localparam logic [5:0] BUBBLE = 6'h30;

  typedef struct packed {
    logic [5:0]  st;
    logic [8:0]  rn;
    logic [6:0]  bi;
    logic [6:0]  bj;
    logic [6:0]  addr;
    logic [6:0]  mi;
    logic [63:0] pr;
    logic        fin;
    logic        ib;
  } tok_t;

  typedef struct packed {
    logic [5:0]  st;
    logic [8:0]  rn;
    logic [6:0]  bi;
    logic [6:0]  bj;
    logic [6:0]  mi;
    logic [63:0] pr;
    logic        fin;
    logic        ib;
    logic [7:0]  c;
    logic [63:0] iv;
    logic        amb;
  } out_t;

  typedef struct {
    tok_t        t;
    logic [7:0]  q;
    logic [63:0] iv;
    logic [7:0]  c;
    logic        amb;
    logic [63:0] eiv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bck_fetch_stage3_if #(.INTV_W(INTV_W), .RD_NUM_W(RD_NUM_W), .DONE_CNT_W(DONE_CNT_W)) bus ();
  bck_fetch_stage3_if #(.INTV_W(INTV_W), .RD_NUM_W(RD_NUM_W), .DONE_CNT_W(2)) bus2 ();

  bck_fetch_stage3 #(.INTV_W(INTV_W), .RD_NUM_W(RD_NUM_W), .DONE_CNT_W(DONE_CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  bck_fetch_stage3 #(.INTV_W(INTV_W), .RD_NUM_W(RD_NUM_W), .DONE_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  // second instance sees identical stimulus and RAM data
  assign bus2.stall                = bus.stall;
  assign bus2.status_q             = bus.status_q;
  assign bus2.read_num_q           = bus.read_num_q;
  assign bus2.backward_i_q         = bus.backward_i_q;
  assign bus2.backward_j_q         = bus.backward_j_q;
  assign bus2.current_rd_addr_q    = bus.current_rd_addr_q;
  assign bus2.min_intv_q           = bus.min_intv_q;
  assign bus2.primary_q            = bus.primary_q;
  assign bus2.finish_sign_q        = bus.finish_sign_q;
  assign bus2.iteration_boundary_q = bus.iteration_boundary_q;
  assign bus2.query_rd_data        = bus.query_rd_data;
  assign bus2.intv_rd_data         = bus.intv_rd_data;

  logic [7:0]  qmem [0:65535];
  logic [63:0] imem [0:127];

  always_ff @(posedge clk) begin
    if (bus.query_rd_en) bus.query_rd_data <= qmem[bus.query_rd_addr];
    if (bus.intv_rd_en)  bus.intv_rd_data  <= imem[bus.intv_rd_addr];
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  out_t        dl[$];
  int unsigned m_done;
  logic [31:0] m_stall;
  tok_t        bub_tok;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic out_t bub_out();
    out_t o;
    o = '0;
    o.st = BUBBLE;
    return o;
  endfunction

  function automatic out_t decode(input tok_t t, input logic [7:0] q, input logic [63:0] iv);
    out_t o;
    o = '0;
    o.st = t.st;
    if (t.st == 6'h04 || t.st == 6'h05) begin
      o.rn = t.rn; o.bi = t.bi; o.bj = t.bj; o.mi = t.mi;
      o.pr = t.pr; o.fin = t.fin; o.ib = t.ib; o.iv = iv;
    end
    if (t.st == 6'h05) begin
      if (q == "A" || q == "a" || q == 8'd0)      o.c = 8'd0;
      else if (q == "C" || q == "c" || q == 8'd1) o.c = 8'd1;
      else if (q == "G" || q == "g" || q == 8'd2) o.c = 8'd2;
      else if (q == "T" || q == "t" || q == 8'd3) o.c = 8'd3;
      else begin
        o.c   = 8'd4;
        o.amb = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rand_base();
    case ($urandom_range(0, 15))
      0: return "A";  1: return "C";  2: return "G";  3: return "T";
      4: return "a";  5: return "c";  6: return "g";  7: return "t";
      8: return 8'd0; 9: return 8'd1; 10: return 8'd2; 11: return 8'd3;
      12: return "N";
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic tok_t rand_tok();
    tok_t t;
    int   r;
    t.rn = 9'($urandom); t.bi = 7'($urandom); t.bj = 7'($urandom);
    t.addr = 7'($urandom); t.mi = 7'($urandom); t.pr = {$urandom, $urandom};
    t.fin = 1'($urandom); t.ib = 1'($urandom);
    r = $urandom_range(0, 9);
    if (r < 5)      t.st = 6'h05;
    else if (r < 7) t.st = 6'h04;
    else if (r < 9) t.st = BUBBLE;
    else            t.st = 6'($urandom);
    return t;
  endfunction

  task automatic model_clear();
    dl.delete();
    dl.push_back(bub_out());
    dl.push_back(bub_out());
    m_done  = 0;
    m_stall = '0;
  endtask

  task automatic drive(input tok_t t, input logic stl);
    bus.stall                = stl;
    bus.status_q             = t.st;
    bus.read_num_q           = t.rn;
    bus.backward_i_q         = t.bi;
    bus.backward_j_q         = t.bj;
    bus.current_rd_addr_q    = t.addr;
    bus.min_intv_q           = t.mi;
    bus.primary_q            = t.pr;
    bus.finish_sign_q        = t.fin;
    bus.iteration_boundary_q = t.ib;
  endtask

  task automatic check_out(input string nm);
    out_t        a1, a2;
    logic [31:0] exp_sc;
    a1 = {bus.status, bus.read_num, bus.backward_i, bus.backward_j, bus.min_intv, bus.primary,
          bus.finish_sign, bus.iteration_boundary, bus.output_c, bus.intv, bus.ambig};
    a2 = {bus2.status, bus2.read_num, bus2.backward_i, bus2.backward_j, bus2.min_intv, bus2.primary,
          bus2.finish_sign, bus2.iteration_boundary, bus2.output_c, bus2.intv, bus2.ambig};
    chk({nm, "_token"}, a1, dl[0]);
    chk({nm, "_token2"}, a2, dl[0]);
    chk({nm, "_reads_done"}, bus.reads_done, (m_done > 1023) ? 1023 : m_done);
    chk({nm, "_reads_done_sat"}, bus2.reads_done, (m_done > 3) ? 3 : m_done);
`ifdef STAGE3_PERF_CNT_EN
    exp_sc = m_stall;
`else
    exp_sc = '0;
`endif
    chk({nm, "_stall_cycles"}, {bus.stall_cycles, bus2.stall_cycles}, {exp_sc, exp_sc});
  endtask

  task automatic step(input tok_t t, input logic stl);
    drive(t, stl);
    #1;
    chk("comb", {bus.stall_up, bus.query_rd_en, bus.intv_rd_en, bus.query_rd_addr, bus.intv_rd_addr,
                 bus2.stall_up, bus2.query_rd_en, bus2.intv_rd_en, bus2.query_rd_addr, bus2.intv_rd_addr},
                {stl, !stl, !stl, t.rn, t.bi, t.addr, stl, !stl, !stl, t.rn, t.bi, t.addr});
    @(posedge clk);
    if (stl) begin
      if (dl[0].st != BUBBLE) m_stall = m_stall + 32'd1;
    end else begin
      void'(dl.pop_front());
      dl.push_back(decode(t, qmem[{t.rn, t.bi}], imem[t.addr]));
      if (dl[0].st == 6'h05 && dl[0].fin) m_done++;
    end
    #1;
    check_out("out");
  endtask

  task automatic do_reset();
    drive(bub_tok, 1'b0);
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset");
  endtask

  vec_t vt[13];
  logic [5:0] done_st[5];

  initial begin
    bub_tok    = '0;
    bub_tok.st = BUBBLE;
    for (int i = 0; i < 65536; i++) qmem[i] = rand_base();
    for (int i = 0; i < 128; i++)   imem[i] = {$urandom, $urandom};

    // directed vectors: {status, query byte, interval word} -> {output_c, ambig, intv}
    for (int i = 0; i < 13; i++) begin
      vt[i].t      = rand_tok();
      vt[i].t.rn   = 9'(20 + i);
      vt[i].t.bi   = 7'(i);
      vt[i].t.addr = 7'(40 + i);
      vt[i].t.st   = 6'h05;
      vt[i].iv     = {$urandom, $urandom};
      vt[i].eiv    = vt[i].iv;
      vt[i].amb    = 1'b0;
    end
    vt[0].t.rn = 9'd3; vt[0].t.bi = 7'd5; vt[0].t.addr = 7'd9;
    vt[0].iv = 64'hABCD; vt[0].eiv = 64'hABCD;
    vt[0].q  = "G";   vt[0].c  = 8'd2;
    vt[1].q  = "N";   vt[1].c  = 8'd4; vt[1].amb = 1'b1;
    vt[2].q  = "T";   vt[2].c  = 8'd3;
    vt[3].q  = "a";   vt[3].c  = 8'd0;
    vt[4].q  = "c";   vt[4].c  = 8'd1;
    vt[5].q  = 8'd2;  vt[5].c  = 8'd2;
    vt[6].q  = 8'd3;  vt[6].c  = 8'd3;
    vt[7].q  = 8'd0;  vt[7].c  = 8'd0;
    vt[8].q  = "g";   vt[8].c  = 8'd2;
    vt[9].q  = "T";   vt[9].c  = 8'd0;  vt[9].t.st = 6'h04;
    vt[10].q = "A";   vt[10].c = 8'd0;  vt[10].t.st = BUBBLE; vt[10].eiv = '0;
    vt[11].q = 8'd4;  vt[11].c = 8'd4;  vt[11].amb = 1'b1;
    vt[12].q = "C";   vt[12].c = 8'd0;  vt[12].t.st = 6'h3F;  vt[12].eiv = '0;

    do_reset();
    step(bub_tok, 1'b0);
    step(bub_tok, 1'b0);

    bus.read_num_q   = 9'd3;
    bus.backward_i_q = 7'd5;
    #1;
    chk("query_rd_addr_3_5", bus.query_rd_addr, 16'h0185);

    for (int i = 0; i < 13; i++) begin
      qmem[{vt[i].t.rn, vt[i].t.bi}] = vt[i].q;
      imem[vt[i].t.addr]             = vt[i].iv;
      step(vt[i].t, 1'b0);
      step(bub_tok, 1'b0);
      chk("tbl_status", bus.status, vt[i].t.st);
      chk("tbl_output_c", bus.output_c, vt[i].c);
      chk("tbl_ambig", bus.ambig, vt[i].amb);
      chk("tbl_intv", bus.intv, vt[i].eiv);
    end

    // stall for 3 cycles with a real token in the output register
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tok_t t;
      t = rand_tok();
      t.st = 6'h05;
      step(t, 1'b0);
    end
    begin
      tok_t hold;
      hold = rand_tok();
      hold.st = 6'h05;
      for (int i = 0; i < 3; i++) step(hold, 1'b1);
`ifdef STAGE3_PERF_CNT_EN
      chk("stall_cycles_3", bus.stall_cycles, 32'd3);
`else
      chk("stall_cycles_off", bus.stall_cycles, 32'd0);
`endif
      step(hold, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(rand_tok(), 1'b0);
    step(bub_tok, 1'b0);
    step(bub_tok, 1'b0);

    // finished-read counting, including saturation of the narrow instance
    do_reset();
    done_st = '{6'h05, 6'h05, 6'h04, 6'h05, 6'h05};
    for (int i = 0; i < 5; i++) begin
      tok_t t;
      t = rand_tok();
      t.st  = done_st[i];
      t.fin = 1'b1;
      step(t, 1'b0);
    end
    step(bub_tok, 1'b0);
    step(bub_tok, 1'b0);
    chk("reads_done_4", bus.reads_done, 10'd4);
    chk("reads_done_sat_3", bus2.reads_done, 2'd3);

    // asynchronous reset between edges while tokens are in flight
    begin
      tok_t ta, tb;
      ta = rand_tok(); ta.st = 6'h05;
      tb = rand_tok(); tb.st = 6'h04;
      step(ta, 1'b0);
      step(tb, 1'b0);
      drive(bub_tok, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_out("async_rst");
      chk("async_rst_status", bus.status, 6'h30);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(bub_tok, 1'b0);
    end

    // random traffic with random stalls
    for (int i = 0; i < 400; i++) step(rand_tok(), ($urandom_range(0, 3) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
